// File: rtl/parity_frame.sv
// Frame parity generator/checker: XORs FRAME_LEN words, compares against chk_in, counts errors.
// Result valid the cycle after the last accepted word; held in HOLD until out_ready, input stalled.
module parity_frame #(
  parameter int WIDTH     = 8,
  parameter int FRAME_LEN = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             odd_mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_in,
  input  logic             chk_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             parity_out,
  output logic             error,
  output logic [7:0]       err_count
);

  localparam int CW = (FRAME_LEN < 1) ? 1 : $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t        state_q, state_d;
  logic          acc_q, acc_d;
  logic [CW-1:0] count_q, count_d;
  logic          mode_q, mode_d;
  logic          parity_q, parity_d;
  logic          error_q, error_d;
  logic [7:0]    err_cnt_q, err_cnt_d;

  logic word_par;
  logic acc_nxt;
  logic mode_nxt;
  logic frame_par;
  logic last_word;

  assign word_par = ^data_in;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    count_d   = count_q;
    mode_d    = mode_q;
    parity_d  = parity_q;
    error_d   = error_q;
    err_cnt_d = err_cnt_q;
    acc_nxt   = acc_q ^ word_par;
    mode_nxt  = mode_q;
    last_word = 1'b0;

    case (state_q)
      IDLE: begin
        acc_nxt  = word_par;
        mode_nxt = odd_mode;
        if (in_valid) begin
          acc_d   = acc_nxt;
          mode_d  = mode_nxt;
          count_d = CW'(1);
          state_d = ACCUM;
          last_word = (FRAME_LEN == 1);
        end
      end
      ACCUM: begin
        if (in_valid) begin
          acc_d   = acc_nxt;
          count_d = count_q + CW'(1);
          last_word = (count_q == LAST_CNT);
        end
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // The frame result is latched on the same edge that accepts the last word.
    frame_par = acc_nxt ^ mode_nxt;
    if (last_word) begin
      count_d  = '0;
      state_d  = HOLD;
      parity_d = frame_par;
      error_d  = (chk_in != frame_par);
      if ((chk_in != frame_par) && (err_cnt_q != 8'hFF))
        err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      acc_q     <= 1'b0;
      count_q   <= '0;
      mode_q    <= 1'b0;
      parity_q  <= 1'b0;
      error_q   <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      mode_q    <= mode_d;
      parity_q  <= parity_d;
      error_q   <= error_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign in_ready   = (state_q != HOLD);
  assign out_valid  = (state_q == HOLD);
  assign parity_out = parity_q;
  assign error      = error_q;
  assign err_count  = err_cnt_q;

endmodule

// File: tb/tb_parity_frame.sv
// Randomized scoreboard bench for parity_frame (WIDTH=8, FRAME_LEN=4).
module tb_parity_frame;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       odd_mode = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] data_in = 8'd0;
  logic       chk_in = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       parity_out;
  logic       error;
  logic [7:0] err_count;

  parity_frame #(.WIDTH(8), .FRAME_LEN(4)) dut (
    .clk(clk), .reset(reset), .odd_mode(odd_mode), .in_valid(in_valid),
    .in_ready(in_ready), .data_in(data_in), .chk_in(chk_in),
    .out_valid(out_valid), .out_ready(out_ready), .parity_out(parity_out),
    .error(error), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       p;
    logic       e;
    logic [7:0] c;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   acc_cyc = -10;
  int   total_acc = 0;
  int   model_cnt = 0;
  int   ordy_mode = 0;  // 0: hold low, 1: hold high, 2: random

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    case (ordy_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom);
    endcase
  end

  // Monitor: pops the scoreboard on every result handshake and checks timing.
  initial begin : monitor
    int   fcnt;
    logic prev_ov;
    logic pend;
    exp_t e;
    fcnt = 0; prev_ov = 1'b0; pend = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        fcnt = 0; prev_ov = 1'b0; pend = 1'b0;
      end else begin
        if (pend) begin
          check("idle_after_handshake", {30'd0, out_valid, in_ready}, 32'd1);
          pend = 1'b0;
        end
        if (out_valid && !prev_ov)
          check("result_latency", cyc, acc_cyc + 1);
        if (in_valid && in_ready) begin
          total_acc++;
          fcnt++;
          if (fcnt == 4) begin
            fcnt = 0;
            acc_cyc = cyc;
          end
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_result", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            check("parity_out", parity_out, e.p);
            check("error", error, e.e);
            check("err_count", err_count, e.c);
          end
          pend = 1'b1;
        end
        prev_ov = out_valid;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    model_cnt = 0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_parity", parity_out, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_err_count", err_count, 8'd0);
    @(posedge clk); #1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the word is accepted.
  task automatic drive_word(input logic [7:0] d, input logic m, input logic c);
    int n;
    in_valid = 1'b1; data_in = d; odd_mode = m; chk_in = c;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        data_in = 8'($urandom); odd_mode = 1'($urandom); chk_in = 1'($urandom);
        return;
      end
      @(posedge clk); #1;
      n++;
      if (n > 500) begin
        check("accept_timeout", 32'd1, 32'd0);
        in_valid = 1'b0;
        return;
      end
    end
  endtask

  task automatic send_frame(input logic [31:0] words, input logic mode,
                            input logic chk, input int gmax);
    exp_t e;
    logic p;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        p = (^words) ^ mode;
        if (chk != p && model_cnt < 255) model_cnt++;
        e.p = p; e.e = (chk != p); e.c = 8'(model_cnt);
        sb.push_back(e);
      end
      drive_word(words[8*i +: 8], (i == 0) ? mode : 1'($urandom),
                 (i == 3) ? chk : 1'($urandom));
      if (gmax > 0)
        repeat ($urandom_range(0, gmax)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic wait_ov(input logic lvl);
    int n;
    n = 0;
    @(negedge clk);
    while (out_valid !== lvl && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("out_valid_timeout", out_valid, lvl);
  endtask

  task automatic expect_hold(input logic p, input logic e, input logic [7:0] c);
    wait_ov(1'b1);
    check("dir_parity", parity_out, p);
    check("dir_error", error, e);
    check("dir_err_count", err_count, c);
    ordy_mode = 1;
    wait_ov(1'b0);
    ordy_mode = 0;
    @(posedge clk); #1;
  endtask

  initial begin : stim
    logic       p0;
    logic       e0;
    int         acc0;
    logic [31:0] w;
    logic       m;
    do_reset();

    // words 0x01,0x03,0x00,0xFF (word 0 in low byte)
    ordy_mode = 0;
    send_frame(32'hFF000301, 1'b0, 1'b1, 0);
    expect_hold(1'b1, 1'b0, 8'd0);
    send_frame(32'hFF000301, 1'b1, 1'b1, 0);
    expect_hold(1'b0, 1'b1, 8'd1);
    send_frame(32'hFF000301, 1'b0, 1'b1, 3);
    expect_hold(1'b1, 1'b0, 8'd1);

    // Backpressure with in_valid held high
    send_frame(32'h12345678, 1'b1, 1'b0, 0);
    wait_ov(1'b1);
    p0 = parity_out; e0 = error; acc0 = total_acc;
    in_valid = 1'b1; data_in = 8'hA5;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_parity_stable", parity_out, p0);
      check("bp_error_stable", error, e0);
    end
    check("bp_no_consume", total_acc, acc0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    ordy_mode = 1;
    wait_ov(1'b0);
    ordy_mode = 0;
    @(posedge clk); #1;

    // Abort mid-frame, then a fresh frame
    drive_word(8'h11, 1'b1, 1'b0);
    drive_word(8'h22, 1'b0, 1'b0);
    do_reset();
    send_frame(32'h00000080, 1'b0, 1'b1, 0);
    expect_hold(1'b1, 1'b0, 8'd0);

    // Abort while holding an errored result
    send_frame(32'h00000080, 1'b0, 1'b0, 0);
    wait_ov(1'b1);
    do_reset();

    // Randomized frames with random gaps and consumer stalls
    ordy_mode = 2;
    for (int f = 0; f < 40; f++) begin
      w = $urandom;
      m = 1'($urandom);
      send_frame(w, m, 1'($urandom), 2);
    end

    // Saturation: every frame deliberately errored
    for (int f = 0; f < 260; f++) begin
      w = $urandom;
      m = 1'($urandom);
      send_frame(w, m, ~((^w) ^ m), 0);
    end
    ordy_mode = 1;
    wait_ov(1'b0);
    @(negedge clk);
    check("sat_err_count", err_count, 8'd255);

    begin : drain
      int n;
      n = 0;
      while (sb.size() != 0 && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("scoreboard_empty", sb.size(), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

endmodule
